// File: rtl/fifo_pkg.sv
// Shared helpers for the width-converting FIFOs: ceiling log2 and
// power-of-two test, usable in parameter and port-width expressions.
// Latency: n/a (constant functions only). Backpressure: n/a.
package fifo_pkg;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_wr_wide_rd_narrow.sv
// Simple dual-port array: DWI-wide write port, registered DWO-wide slice read port.
// Latency: read data appears 1 cycle after re_i. Backpressure: none, caller gates we_i/re_i.
// Ports: clk, rstn (sync, clears read register only), we_i/waddr_i/wdata_i write port,
//        re_i/raddr_i/rsel_i read word and slice select, rdata_o registered slice.
module ram_wr_wide_rd_narrow #(
  parameter int AW  = 3,
  parameter int DWI = 16,
  parameter int DWO = 4,
  parameter int SBW = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           we_i,
  input  logic [AW-1:0]  waddr_i,
  input  logic [DWI-1:0] wdata_i,
  input  logic           re_i,
  input  logic [AW-1:0]  raddr_i,
  input  logic [SBW-1:0] rsel_i,
  output logic [DWO-1:0] rdata_o
);

  logic [DWI-1:0] mem_q [2**AW];
  logic [DWO-1:0] rdata_q;

  // Storage is deliberately left unreset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Slice 0 is the least-significant DWO bits of the stored word.
  always_ff @(posedge clk) begin
    if (!rstn)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i][DWO*rsel_i +: DWO];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_shrink.sv
// Single-clock FIFO, DWI-bit words in, DWO-bit slices out (LS slice first).
// Latency: write readable next cycle; rdata/rvalid 1 cycle after accepted read.
// Backpressure: writes dropped while wfull, reads ignored while rempty.
// Ports: clk, rstn (sync active-low), winc/wdata write side, rinc/rdata/rvalid read side,
//        wfull, rempty, prog_empty (rcount <= PROG_DEPTH), rcount (unread narrow slices).
module sync_fifo_shrink
  import fifo_pkg::*;
#(
  parameter  int AWI        = 3,
  parameter  int DWI        = 16,
  parameter  int DWO        = 4,
  parameter  int PROG_DEPTH = 4,
  localparam int RATIO      = DWI / DWO,
  localparam int SB         = clog2(RATIO),
  localparam int AWO        = AWI + SB
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           winc,
  input  logic [DWI-1:0] wdata,
  input  logic           rinc,
  output logic [DWO-1:0] rdata,
  output logic           rvalid,
  output logic           wfull,
  output logic           rempty,
  output logic           prog_empty,
  output logic [AWO:0]   rcount
);

  if (DWI % DWO != 0) begin : g_err_multiple
    $error("sync_fifo_shrink: DWI must be a multiple of DWO");
  end
  if (!is_pow2(RATIO)) begin : g_err_pow2
    $error("sync_fifo_shrink: DWI/DWO must be a power of two");
  end

  localparam int            SBW      = (SB == 0) ? 1 : SB;
  localparam logic [AWI:0]  DEPTH_W  = {1'b1, {AWI{1'b0}}};
  localparam logic [AWI:0]  W_ONE    = {{AWI{1'b0}}, 1'b1};
  localparam logic [AWO:0]  R_ONE    = {{AWO{1'b0}}, 1'b1};

  logic [AWI:0]   wptr_q, wptr_d;
  logic [AWO:0]   rptr_q, rptr_d;
  logic           rvalid_q, rvalid_d;
  logic [AWI:0]   occupied;
  logic           wr_acc, rd_acc;
  logic [SBW-1:0] rsel;

  // Wide write pointer scaled to slice units; wrap flags line up after the shift.
  assign rcount     = ((AWO+1)'(wptr_q) << SB) - rptr_q;
  // A partially drained entry still counts: compare against the read word index.
  assign occupied   = wptr_q - rptr_q[AWO:SB];
  assign wfull      = (occupied == DEPTH_W);
  assign rempty     = (rcount == '0);
  assign prog_empty = (rcount <= (AWO+1)'(PROG_DEPTH));

  assign wr_acc = winc && !wfull;
  assign rd_acc = rinc && !rempty;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    rvalid_d = rd_acc;
    if (wr_acc) wptr_d = wptr_q + W_ONE;
    if (rd_acc) rptr_d = rptr_q + R_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  if (SB == 0) begin : g_sel_none
    assign rsel = '0;
  end else begin : g_sel
    assign rsel = rptr_q[SBW-1:0];
  end

  ram_wr_wide_rd_narrow #(
    .AW  (AWI),
    .DWI (DWI),
    .DWO (DWO),
    .SBW (SBW)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (wr_acc && rstn),
    .waddr_i (wptr_q[AWI-1:0]),
    .wdata_i (wdata),
    .re_i    (rd_acc),
    .raddr_i (rptr_q[AWO-1:SB]),
    .rsel_i  (rsel),
    .rdata_o (rdata)
  );

  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_sync_fifo_shrink.sv
module tb_sync_fifo_shrink;

  localparam int RATIO = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        winc;
  logic [15:0] wdata;
  logic        rinc;
  logic [3:0]  rdata;
  logic        rvalid;
  logic        wfull;
  logic        rempty;
  logic        prog_empty;
  logic [5:0]  rcount;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of unread narrow slices in read order.
  logic [3:0] mq[$];
  logic [3:0] exp_rdata = 4'h0;
  bit         exp_rvalid = 1'b0;

  sync_fifo_shrink #(
    .AWI(3), .DWI(16), .DWO(4), .PROG_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
    .prog_empty(prog_empty), .rcount(rcount)
  );

  always #5 clk = ~clk;

  function automatic bit m_full();
    // Wide entries still holding at least one unread slice.
    return ((mq.size() + RATIO - 1) / RATIO) >= DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("rcount",     32'(rcount),     32'(mq.size()));
    chk("rempty",     32'(rempty),     32'(mq.size() == 0));
    chk("wfull",      32'(wfull),      32'(m_full()));
    chk("prog_empty", 32'(prog_empty), 32'(mq.size() <= 4));
    chk("rvalid",     32'(rvalid),     32'(exp_rvalid));
    chk("rdata",      32'(rdata),      32'(exp_rdata));
  endtask

  // One clock cycle: drive, advance model on the edge, check 1 time unit later.
  task automatic step(input bit w, input logic [15:0] wd, input bit r, input bit rs = 1'b1);
    bit wacc, racc;
    rstn  = rs;
    winc  = w;
    wdata = wd;
    rinc  = r;
    wacc  = rs && w && !m_full();
    racc  = rs && r && (mq.size() != 0);
    @(posedge clk);
    if (!rs) begin
      mq.delete();
      exp_rdata  = 4'h0;
      exp_rvalid = 1'b0;
    end else begin
      exp_rvalid = racc;
      if (racc) exp_rdata = mq.pop_front();
      if (wacc) for (int i = 0; i < RATIO; i++) mq.push_back(wd[i*4 +: 4]);
    end
    #1;
    chk_all();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mq.size() != 0 && guard < 100) begin
      step(1'b0, 16'h0, 1'b1);
      guard++;
    end
    chk("drain_done", 32'(rempty), 32'd1);
  endtask

  initial begin
    logic [3:0]  s1_exp [4];
    logic [15:0] words [8];
    logic [3:0]  held;

    rstn = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    chk("reset_rcount", 32'(rcount), 32'd0);
    chk("reset_rempty", 32'(rempty), 32'd1);

    // Reset and first word: slices come out D, C, B, A.
    s1_exp = '{4'hD, 4'hC, 4'hB, 4'hA};
    step(1'b1, 16'hABCD, 1'b0);
    chk("s1_rcount4", 32'(rcount), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0, 1'b1);
      chk("s1_slice", 32'(rdata), 32'(s1_exp[i]));
      chk("s1_rcount", 32'(rcount), 32'(3 - i));
    end
    chk("s1_empty", 32'(rempty), 32'd1);

    // Fill to full, then a dropped 9th write.
    for (int i = 0; i < 8; i++) begin
      words[i] = 16'($urandom);
      step(1'b1, words[i], 1'b0);
    end
    chk("fill_wfull", 32'(wfull), 32'd1);
    chk("fill_rcount", 32'(rcount), 32'd32);
    step(1'b1, 16'hFFFF, 1'b0);
    chk("drop_rcount", 32'(rcount), 32'd32);
    step(1'b0, 16'h0, 1'b1);
    chk("first_slice", 32'(rdata), 32'(words[0][3:0]));

    // Full boundary: entry stays occupied until its last slice leaves.
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    chk("boundary_full3", 32'(wfull), 32'd1);
    step(1'b1, 16'h1234, 1'b1);
    chk("boundary_free", 32'(wfull), 32'd0);
    chk("boundary_rcount", 32'(rcount), 32'd28);
    drain();

    // Simultaneous read and write from rcount 6, across pointer wrap.
    step(1'b1, 16'($urandom), 1'b0);
    step(1'b1, 16'($urandom), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    chk("sim_start6", 32'(rcount), 32'd6);
    step(1'b1, 16'($urandom), 1'b1);
    chk("sim_plus3", 32'(rcount), 32'd9);
    for (int i = 0; i < 9; i++) step(1'b1, 16'($urandom), 1'b1);
    drain();

    // Read on empty: no valid, data held.
    held = exp_rdata;
    step(1'b0, 16'h0, 1'b1);
    chk("empty_rvalid", 32'(rvalid), 32'd0);
    chk("empty_hold", 32'(rdata), 32'(held));

    // Threshold at 4/5, then reset mid-stream with requests asserted.
    step(1'b1, 16'($urandom), 1'b0);
    step(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);
    chk("prog_at5", 32'(prog_empty), 32'd0);
    step(1'b0, 16'h0, 1'b1);
    chk("prog_at4", 32'(prog_empty), 32'd1);
    step(1'b1, 16'($urandom), 1'b1);
    chk("prog_at7", 32'(prog_empty), 32'd0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("midrst_rempty", 32'(rempty), 32'd1);
    chk("midrst_rcount", 32'(rcount), 32'd0);

    // Random traffic against the model, occasional reset.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) != 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
